frame_bank_scheduler: RTL and testbench

- Double-buffer (ping-pong) scheduler for the camera frame BRAM, split into two banks selected by the address MSB.
- Sequences camera writes into one bank while a downstream reader (VGA or processing) owns the other bank.
- Swaps banks at end of frame only when the reader has released its bank; otherwise drops the frame and rewrites the same bank.
- Sits between the camera capture and BRAM write port on one side and the reader's bank-request handshake on the other.

---
 rtl/frame_bank_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_scheduler.sv
// Ping-pong bank scheduler for the camera frame BRAM.
// The camera writes one bank while the reader owns the other. At each end of
// frame the banks swap only if the reader is not holding a bank; otherwise the
// frame is dropped and the same bank is rewritten.
//
// Reader handshake: rd_req may be a pulse or a level. It is taken only in
// RD_IDLE, and it is remembered if no frame is available yet. rd_grant is a
// single-cycle acknowledge, and rd_bank is valid from that cycle onward. The
// reader owns rd_bank until rd_release is sampled in RD_BUSY. rd_req and
// rd_release are ignored in every other state.
//
// Debug encodings: dbg_wr_state 0=WR_SYNC 1=WR_ACTIVE;
// dbg_rd_state 0=RD_IDLE 1=RD_GRANT 2=RD_BUSY.
module frame_bank_scheduler #(
  parameter int PIX_ADDR_W   = 17,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 8
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  cam_pixel_valid,
  input  logic                  cam_frame_done,
  output logic                  bram_we,
  output logic [PIX_ADDR_W:0]   bram_waddr,
  input  logic                  rd_req,
  output logic                  rd_grant,
  output logic                  rd_bank,
  input  logic                  rd_release,
  output logic                  frame_avail,
  output logic [CNT_W-1:0]      frames_dropped,
  output logic                  wr_overflow,
  output logic [1:0]            dbg_wr_state,
  output logic [1:0]            dbg_rd_state,
  output logic                  dbg_wr_bank
);

  typedef enum logic [1:0] {
    WR_SYNC   = 2'd0,
    WR_ACTIVE = 2'd1
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_GRANT = 2'd1,
    RD_BUSY  = 2'd2
  } rd_state_t;

  localparam logic [PIX_ADDR_W-1:0] LAST_IDX = PIX_ADDR_W'(FRAME_PIXELS - 1);

  wr_state_t               wr_state, wr_state_nxt;
  rd_state_t               rd_state, rd_state_nxt;
  logic                    fd_d;
  logic                    fd_rise;
  logic                    wr_bank, wr_bank_nxt;
  logic [PIX_ADDR_W-1:0]   idx, idx_nxt;
  logic                    idx_full, idx_full_nxt;
  logic                    we_nxt;
  logic [PIX_ADDR_W:0]     waddr_nxt;
  logic                    ovf_nxt;
  logic                    pub_bank, pub_nxt;
  logic                    avail_nxt;
  logic [CNT_W-1:0]        dropped_nxt;
  logic                    rd_bank_nxt;
  logic                    req_pend, req_pend_nxt;
  logic                    reader_free;
  logic                    swap;
  logic                    drop;

  assign fd_rise      = cam_frame_done & ~fd_d;
  assign rd_grant     = (rd_state == RD_GRANT);
  assign dbg_wr_state = wr_state;
  assign dbg_rd_state = rd_state;
  assign dbg_wr_bank  = wr_bank;

  // The frame_done delay follows the input even in reset. A level that is
  // already high when reset drops is therefore not seen as an edge.
  always_ff @(posedge sysclk) begin
    fd_d <= cam_frame_done;
  end

  // State register for both FSMs and all datapath registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_state       <= WR_SYNC;
      rd_state       <= RD_IDLE;
      wr_bank        <= 1'b0;
      idx            <= '0;
      idx_full       <= 1'b0;
      bram_we        <= 1'b0;
      bram_waddr     <= '0;
      wr_overflow    <= 1'b0;
      pub_bank       <= 1'b0;
      frame_avail    <= 1'b0;
      frames_dropped <= '0;
      rd_bank        <= 1'b1;
      req_pend       <= 1'b0;
    end else begin
      wr_state       <= wr_state_nxt;
      rd_state       <= rd_state_nxt;
      wr_bank        <= wr_bank_nxt;
      idx            <= idx_nxt;
      idx_full       <= idx_full_nxt;
      bram_we        <= we_nxt;
      bram_waddr     <= waddr_nxt;
      wr_overflow    <= ovf_nxt;
      pub_bank       <= pub_nxt;
      frame_avail    <= avail_nxt;
      frames_dropped <= dropped_nxt;
      rd_bank        <= rd_bank_nxt;
      req_pend       <= req_pend_nxt;
    end
  end

  // Next-state logic: the writer sequence, the swap decision, then the reader.
  // The reader section runs last, so a grant in the same cycle as a swap picks
  // up the freshly published bank and consumes its frame_avail.
  always_comb begin
    wr_state_nxt = wr_state;
    rd_state_nxt = rd_state;
    wr_bank_nxt  = wr_bank;
    idx_nxt      = idx;
    idx_full_nxt = idx_full;
    we_nxt       = 1'b0;
    waddr_nxt    = bram_waddr;
    ovf_nxt      = wr_overflow;
    pub_nxt      = pub_bank;
    avail_nxt    = frame_avail;
    dropped_nxt  = frames_dropped;
    rd_bank_nxt  = rd_bank;
    req_pend_nxt = req_pend;
    swap         = 1'b0;
    drop         = 1'b0;

    // A release arriving with the frame edge frees the reader first.
    reader_free = (rd_state == RD_IDLE) || ((rd_state == RD_BUSY) && rd_release);

    case (wr_state)
      WR_SYNC: begin
        if (fd_rise) wr_state_nxt = WR_ACTIVE;
      end
      WR_ACTIVE: begin
        if (cam_pixel_valid) begin
          we_nxt    = 1'b1;
          waddr_nxt = {wr_bank, idx};
          // The last location absorbs extra pixels. The first rewrite of it
          // flags overflow.
          if (idx == LAST_IDX) begin
            if (idx_full) ovf_nxt = 1'b1;
            idx_full_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
        if (fd_rise) begin
          idx_nxt      = '0;
          idx_full_nxt = 1'b0;
          if (reader_free) swap = 1'b1;
          else             drop = 1'b1;
        end
      end
      default: wr_state_nxt = WR_SYNC;
    endcase

    if (swap) begin
      wr_bank_nxt = ~wr_bank;
      pub_nxt     = wr_bank;
      avail_nxt   = 1'b1;
    end
    if (drop && (frames_dropped != {CNT_W{1'b1}})) begin
      dropped_nxt = frames_dropped + 1'b1;
    end

    case (rd_state)
      RD_IDLE: begin
        if ((rd_req || req_pend) && frame_avail) begin
          rd_state_nxt = RD_GRANT;
          rd_bank_nxt  = pub_nxt;
          avail_nxt    = 1'b0;
          req_pend_nxt = 1'b0;
        end else if (rd_req) begin
          req_pend_nxt = 1'b1;
        end
      end
      RD_GRANT: rd_state_nxt = RD_BUSY;
      RD_BUSY: begin
        if (rd_release) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Bench for frame_bank_scheduler: scenario tasks plus a frame-level model.
module tb_frame_bank_scheduler;
  localparam int PIX_ADDR_W   = 17;
  localparam int FRAME_PIXELS = 76800;
  localparam int CNT_W        = 8;
  localparam int AW           = PIX_ADDR_W + 1;
  localparam logic [PIX_ADDR_W-1:0] LAST_PIX = PIX_ADDR_W'(FRAME_PIXELS - 1);

  // ---------------- clock / reset ----------------
  logic sysclk = 1'b0;
  logic rst = 1'b1;
  logic cam_pixel_valid = 1'b0, cam_frame_done = 1'b0, rd_req = 1'b0, rd_release = 1'b0;
  logic bram_we, rd_grant, rd_bank, frame_avail, wr_overflow, dbg_wr_bank;
  logic [AW-1:0] bram_waddr;
  logic [CNT_W-1:0] frames_dropped;
  logic [1:0] dbg_wr_state, dbg_rd_state;

  always #5 sysclk = ~sysclk;

  frame_bank_scheduler #(.PIX_ADDR_W(PIX_ADDR_W), .FRAME_PIXELS(FRAME_PIXELS), .CNT_W(CNT_W)) dut (
    .sysclk(sysclk), .rst(rst), .cam_pixel_valid(cam_pixel_valid), .cam_frame_done(cam_frame_done),
    .bram_we(bram_we), .bram_waddr(bram_waddr), .rd_req(rd_req), .rd_grant(rd_grant),
    .rd_bank(rd_bank), .rd_release(rd_release), .frame_avail(frame_avail),
    .frames_dropped(frames_dropped), .wr_overflow(wr_overflow),
    .dbg_wr_state(dbg_wr_state), .dbg_rd_state(dbg_rd_state), .dbg_wr_bank(dbg_wr_bank)
  );

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- reference model (frame-level) ----------------
  logic [AW-1:0] exp_q[$];
  bit m_fd_d = 0, m_active = 0, m_wr_bank = 0, m_pub = 0, m_avail = 0, m_ovf = 0, m_pend = 0, m_rd_bank = 1;
  int m_cnt = 0, m_dropped = 0;
  int m_rd = 0; // 0 reader free, 1 grant cycle, 2 reader holds a bank

  function automatic void model_step(bit r, bit pv, bit fd, bit req, bit rel);
    bit fd_rise, free, swap, drop, grant, new_pub;
    logic [PIX_ADDR_W-1:0] pix;
    fd_rise = fd && !m_fd_d;
    m_fd_d = fd;
    if (r) begin
      m_active = 0; m_cnt = 0; m_wr_bank = 0; m_pub = 0; m_avail = 0; m_dropped = 0;
      m_ovf = 0; m_rd = 0; m_pend = 0; m_rd_bank = 1;
      return;
    end
    // Pixel n of a frame lands at min(n, FRAME_PIXELS-1); any beyond FRAME_PIXELS overflow.
    if (m_active && pv) begin
      pix = PIX_ADDR_W'((m_cnt < FRAME_PIXELS) ? m_cnt : FRAME_PIXELS - 1);
      exp_q.push_back({m_wr_bank, pix});
      if (m_cnt >= FRAME_PIXELS) m_ovf = 1;
      m_cnt++;
    end
    free = (m_rd == 0) || (m_rd == 2 && rel);
    swap = m_active && fd_rise && free;
    drop = m_active && fd_rise && !free;
    new_pub = swap ? m_wr_bank : m_pub;
    grant = (m_rd == 0) && (req || m_pend) && m_avail;
    if (m_rd == 0) begin
      if (grant) begin m_rd = 1; m_rd_bank = new_pub; m_pend = 0; end
      else if (req) m_pend = 1;
    end else if (m_rd == 1) m_rd = 2;
    else if (rel) m_rd = 0;
    if (swap) begin m_pub = new_pub; m_wr_bank = !m_wr_bank; m_avail = 1; end
    if (grant) m_avail = 0;
    if (drop) m_dropped = (m_dropped < 255) ? m_dropped + 1 : 255;
    if (fd_rise) begin m_active = 1; m_cnt = 0; end
  endfunction

  // ---------------- scoreboard: writes and bank invariant ----------------
  int wr_seen = 0;
  logic [AW-1:0] last_waddr = '0, prev_waddr = '0, exp_w;

  always @(negedge sysclk) begin
    if (bram_we === 1'b1) begin
      wr_seen++;
      prev_waddr = last_waddr;
      last_waddr = bram_waddr;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL write_unexpected got_addr=%h exp=no write", bram_waddr);
      end else begin
        exp_w = exp_q.pop_front();
        if (bram_waddr !== exp_w) begin n_fail++; $display("FAIL write_addr got=%h exp=%h", bram_waddr, exp_w); end
      end
    end
    if (m_rd == 2) begin
      n_checks++;
      if (rd_bank === dbg_wr_bank) begin n_fail++; $display("FAIL bank_invariant rd_bank=%b wr_bank=%b exp=different", rd_bank, dbg_wr_bank); end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(bit pv, bit fd, bit req, bit rel);
    cam_pixel_valid = pv; cam_frame_done = fd; rd_req = req; rd_release = rel;
    @(posedge sysclk);
    model_step(rst, pv, fd, req, rel);
    #1;
  endtask

  task automatic pixels(int n, bit burst);
    for (int i = 0; i < n; i++) begin
      if (!burst) while ($urandom_range(0, 3) == 0) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
    end
  endtask

  task automatic end_frame(bit req, bit rel);
    step(0, 1, req, rel);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1;
    repeat (3) step(0, 0, 0, 0);
    n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%b exp=0", bram_we); end
    n_checks++; if (bram_waddr !== '0) begin n_fail++; $display("FAIL rst_waddr got=%h exp=0", bram_waddr); end
    n_checks++; if (frame_avail !== 1'b0) begin n_fail++; $display("FAIL rst_avail got=%b exp=0", frame_avail); end
    n_checks++; if (frames_dropped !== '0) begin n_fail++; $display("FAIL rst_dropped got=%0d exp=0", frames_dropped); end
    n_checks++; if (wr_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got=%b exp=0", wr_overflow); end
    n_checks++; if (rd_grant !== 1'b0) begin n_fail++; $display("FAIL rst_grant got=%b exp=0", rd_grant); end
    n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL rst_rd_bank got=%b exp=1", rd_bank); end
    n_checks++; if (dbg_wr_bank !== 1'b0) begin n_fail++; $display("FAIL rst_wr_bank got=%b exp=0", dbg_wr_bank); end
    n_checks++; if (dbg_wr_state !== 2'd0 || dbg_rd_state !== 2'd0) begin n_fail++; $display("FAIL rst_states got=%0d/%0d exp=0/0", dbg_wr_state, dbg_rd_state); end
    rst = 0;
  endtask

  task automatic test_first_frame();
    int w0;
    w0 = wr_seen;
    pixels(5, 0);                 // partial frame before sync: must not be written
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    pixels(10, 1);
    end_frame(0, 0);
    n_checks++; if (wr_seen - w0 != 10) begin n_fail++; $display("FAIL s1_write_count got=%0d exp=10", wr_seen - w0); end
    n_checks++; if (last_waddr !== 18'd9) begin n_fail++; $display("FAIL s1_last_addr got=%h exp=9", last_waddr); end
    n_checks++; if (frame_avail !== 1'b1) begin n_fail++; $display("FAIL s1_avail got=%b exp=1", frame_avail); end
    n_checks++; if (dbg_wr_bank !== 1'b1) begin n_fail++; $display("FAIL s1_wr_bank got=%b exp=1", dbg_wr_bank); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL s1_missing_writes got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_grant();
    step(0, 0, 1, 0);
    n_checks++; if (rd_grant !== 1'b1) begin n_fail++; $display("FAIL s2_grant got=%b exp=1", rd_grant); end
    n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL s2_rd_bank got=%b exp=0", rd_bank); end
    n_checks++; if (frame_avail !== 1'b0) begin n_fail++; $display("FAIL s2_avail got=%b exp=0", frame_avail); end
    step(0, 0, 0, 0);
    n_checks++; if (rd_grant !== 1'b0) begin n_fail++; $display("FAIL s2_grant_pulse got=%b exp=0", rd_grant); end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++; if (last_waddr !== 18'h20000) begin n_fail++; $display("FAIL s2_bank1_start got=%h exp=20000", last_waddr); end
    pixels($urandom_range(3, 20), 0);
  endtask

  task automatic test_drop();
    end_frame(0, 0);
    pixels($urandom_range(1, 15), 0);
    end_frame(0, 0);
    n_checks++; if (frames_dropped !== 8'd2) begin n_fail++; $display("FAIL s3_dropped got=%0d exp=2", frames_dropped); end
    n_checks++; if (dbg_wr_bank !== 1'b1) begin n_fail++; $display("FAIL s3_wr_bank got=%b exp=1", dbg_wr_bank); end
    n_checks++; if (frame_avail !== 1'b0) begin n_fail++; $display("FAIL s3_avail got=%b exp=0", frame_avail); end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++; if (last_waddr !== 18'h20000) begin n_fail++; $display("FAIL s3_restart_addr got=%h exp=20000", last_waddr); end
    step(0, 0, 0, 1);
    pixels($urandom_range(1, 15), 0);
    end_frame(0, 0);
    n_checks++; if (dbg_wr_bank !== 1'b0) begin n_fail++; $display("FAIL s3_swap_bank got=%b exp=0", dbg_wr_bank); end
    n_checks++; if (frame_avail !== 1'b1) begin n_fail++; $display("FAIL s3_swap_avail got=%b exp=1", frame_avail); end
    n_checks++; if (frames_dropped !== 8'd2) begin n_fail++; $display("FAIL s3_dropped_after got=%0d exp=2", frames_dropped); end
  endtask

  task automatic test_release_same_cycle();
    step(0, 0, 1, 0);
    n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL s4_rd_bank got=%b exp=1", rd_bank); end
    step(0, 0, 0, 0);
    pixels($urandom_range(2, 12), 0);
    end_frame(0, 1);
    n_checks++; if (dbg_wr_bank !== 1'b1) begin n_fail++; $display("FAIL s4_swap_bank got=%b exp=1", dbg_wr_bank); end
    n_checks++; if (frames_dropped !== 8'd2) begin n_fail++; $display("FAIL s4_dropped got=%0d exp=2", frames_dropped); end
    n_checks++; if (frame_avail !== 1'b1) begin n_fail++; $display("FAIL s4_avail got=%b exp=1", frame_avail); end
  endtask

  task automatic test_req_with_swap();
    pixels($urandom_range(2, 12), 0);
    step(0, 1, 1, 0);
    n_checks++; if (rd_grant !== 1'b1) begin n_fail++; $display("FAIL rs_grant got=%b exp=1", rd_grant); end
    n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL rs_new_bank got=%b exp=1", rd_bank); end
    n_checks++; if (frame_avail !== 1'b0) begin n_fail++; $display("FAIL rs_avail got=%b exp=0", frame_avail); end
    n_checks++; if (dbg_wr_bank !== 1'b0) begin n_fail++; $display("FAIL rs_wr_bank got=%b exp=0", dbg_wr_bank); end
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
  endtask

  task automatic test_pending();
    int waited;
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    n_checks++; if (rd_grant !== 1'b0) begin n_fail++; $display("FAIL pend_early_grant got=%b exp=0", rd_grant); end
    pixels($urandom_range(2, 12), 0);
    step(0, 1, 0, 0);
    waited = 0;
    while (rd_grant !== 1'b1 && waited < 5) begin step(0, 0, 0, 0); waited++; end
    n_checks++; if (rd_grant !== 1'b1 || waited != 1) begin n_fail++; $display("FAIL pend_grant got=%b after %0d cycles exp=1 after 1", rd_grant, waited); end
    n_checks++; if (rd_bank !== m_rd_bank || rd_bank !== 1'b0) begin n_fail++; $display("FAIL pend_rd_bank got=%b exp=0", rd_bank); end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
  endtask

  task automatic test_drop_saturate();
    pixels($urandom_range(2, 12), 0);
    end_frame(0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin step(0, 1, 0, 0); step(0, 0, 0, 0); end
    n_checks++; if (frames_dropped !== 8'hFF) begin n_fail++; $display("FAIL sat_dropped got=%0d exp=255", frames_dropped); end
    n_checks++; if (dbg_wr_bank !== m_wr_bank) begin n_fail++; $display("FAIL sat_wr_bank got=%b exp=%b", dbg_wr_bank, m_wr_bank); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] e;
    e = {m_wr_bank, LAST_PIX};
    pixels(FRAME_PIXELS, 1);
    n_checks++; if (wr_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got=%b exp=0", wr_overflow); end
    step(1, 0, 0, 0);
    n_checks++; if (wr_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b exp=1", wr_overflow); end
    step(0, 0, 0, 0);
    n_checks++; if (last_waddr !== e || prev_waddr !== e) begin n_fail++; $display("FAIL ovf_last_two got=%h,%h exp=%h", prev_waddr, last_waddr, e); end
    end_frame(0, 0);
    pixels(3, 0);
    n_checks++; if (wr_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", wr_overflow); end
    step(0, 0, 0, 1);
  endtask

  task automatic test_random();
    bit fd;
    fd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!fd && $urandom_range(0, 11) == 0) fd = 1;
      else if (fd && $urandom_range(0, 2) == 0) fd = 0;
      step(bit'($urandom_range(0, 1)), fd, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      n_checks++;
      if (frame_avail !== m_avail || rd_grant !== (m_rd == 1) || rd_bank !== m_rd_bank ||
          frames_dropped !== CNT_W'(m_dropped) || wr_overflow !== m_ovf || dbg_wr_bank !== m_wr_bank) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got avail=%b grant=%b rd_bank=%b drop=%0d ovf=%b wr_bank=%b exp %b %b %b %0d %b %b",
                 i, frame_avail, rd_grant, rd_bank, frames_dropped, wr_overflow, dbg_wr_bank,
                 m_avail, m_rd == 1, m_rd_bank, m_dropped, m_ovf, m_wr_bank);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int w0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    pixels(500, 1);
    rst = 1;
    step(1, 0, 0, 0);
    rst = 0;
    n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL mr_we got=%b exp=0", bram_we); end
    n_checks++; if (frame_avail !== 1'b0 || rd_grant !== 1'b0) begin n_fail++; $display("FAIL mr_avail_grant got=%b/%b exp=0/0", frame_avail, rd_grant); end
    n_checks++; if (frames_dropped !== '0 || wr_overflow !== 1'b0) begin n_fail++; $display("FAIL mr_counters got=%0d/%b exp=0/0", frames_dropped, wr_overflow); end
    n_checks++; if (rd_bank !== 1'b1 || dbg_wr_bank !== 1'b0) begin n_fail++; $display("FAIL mr_banks got=%b/%b exp=1/0", rd_bank, dbg_wr_bank); end
    w0 = wr_seen;
    pixels(20, 0);
    step(0, 0, 0, 0);
    n_checks++; if (wr_seen != w0) begin n_fail++; $display("FAIL mr_sync_writes got=%0d exp=0", wr_seen - w0); end
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    pixels(3, 1);
    step(0, 0, 0, 0);
    n_checks++; if (wr_seen - w0 != 3 || last_waddr !== 18'd2) begin n_fail++; $display("FAIL mr_resume got=%0d writes last=%h exp=3 writes last=2", wr_seen - w0, last_waddr); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_frame();
    test_grant();
    test_drop();
    test_release_same_cycle();
    test_req_with_swap();
    test_pending();
    test_drop_saturate();
    test_overflow();
    test_random();
    test_reset_midframe();
    step(0, 0, 0, 0);
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_missing_writes got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
